// File: rtl/dco_freq_ctrl_if.sv
// Control and status bundle between the frequency-acquisition controller and its environment.
// master drives start/stop/target/fb_in; slave (the controller) drives the DCO word and status.
// No handshake: every signal is level-sampled on the reference clock.
interface dco_freq_ctrl_if #(parameter int CNT_W = 12);
  logic             start;
  logic             stop;
  logic [CNT_W-1:0] target;
  logic             fb_in;
  logic [9:0]       lambda;
  logic             e;
  logic             lock;
  logic             busy;
  logic [CNT_W-1:0] meas_cnt;

  modport master (
    output start, stop, target, fb_in,
    input  lambda, e, lock, busy, meas_cnt
  );

  modport slave (
    input  start, stop, target, fb_in,
    output lambda, e, lock, busy, meas_cnt
  );
endinterface

// File: rtl/dco_freq_ctrl.sv
// DCO frequency acquisition: 10-step SAR on lambda, then +/-1 tracking around target.
// Latency: SETTLE_CYC + WINDOW + 1 cycles per lambda update; outputs registered.
// No backpressure: start is taken only in IDLE, stop aborts from any state.
module dco_freq_ctrl #(
  parameter int CNT_W      = 12,
  parameter int WINDOW     = 256,
  parameter int SETTLE_CYC = 16,
  parameter int TOL        = 1
) (
  input  logic             clk,
  input  logic             rst,
  dco_freq_ctrl_if.slave   bus
);

  localparam int CYC_MAX = (WINDOW > SETTLE_CYC) ? WINDOW : SETTLE_CYC;
  localparam int CYC_W   = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;
  localparam logic [CYC_W-1:0]        SETTLE_LAST = CYC_W'(SETTLE_CYC - 1);
  localparam logic [CYC_W-1:0]        WINDOW_LAST = CYC_W'(WINDOW - 1);
  localparam logic [9:0]              LAMBDA_MID  = 10'b10_0000_0000;
  localparam logic signed [CNT_W:0]   TOL_S       = (CNT_W+1)'(TOL);

  typedef enum logic [2:0] {
    IDLE, SETTLE, MEASURE, UPDATE, TRACK_SETTLE, TRACK_MEASURE, TRACK_UPDATE
  } state_t;

  state_t                  state;
  logic [CYC_W-1:0]        cyc_cnt;
  logic [3:0]              idx;
  logic [9:0]              lambda_q;
  logic                    e_q;
  logic                    lock_q;
  logic                    busy_q;
  logic [CNT_W-1:0]        meas_q;
  logic [CNT_W-1:0]        edge_cnt;
  logic [CNT_W-1:0]        edge_cnt_nxt;
  logic [2:0]              fb_sync;
  logic                    fb_rise;
  logic [9:0]              bit_mask;
  logic [9:0]              sar_lambda;
  logic signed [CNT_W:0]   err;

  // fb_sync[0..1] is the metastability pair, fb_sync[2] the delayed copy for edge detect
  always_ff @(posedge clk) begin
    if (rst) fb_sync <= '0;
    else     fb_sync <= {fb_sync[1:0], bus.fb_in};
  end

  assign fb_rise = fb_sync[1] & ~fb_sync[2];

  always_comb begin
    edge_cnt_nxt = edge_cnt;
    if (fb_rise && (edge_cnt != '1)) edge_cnt_nxt = edge_cnt + CNT_W'(1);
  end

  // SAR step: drop the trial bit if we overshot, then arm the next lower bit
  always_comb begin
    bit_mask   = 10'd1 << idx;
    sar_lambda = ((meas_q > bus.target) ? (lambda_q & ~bit_mask) : lambda_q) | (bit_mask >> 1);
    err        = $signed({1'b0, meas_q}) - $signed({1'b0, bus.target});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cyc_cnt  <= '0;
      idx      <= 4'd9;
      lambda_q <= LAMBDA_MID;
      e_q      <= 1'b0;
      lock_q   <= 1'b0;
      busy_q   <= 1'b0;
      meas_q   <= '0;
      edge_cnt <= '0;
    end else if (bus.stop) begin
      state  <= IDLE;
      e_q    <= 1'b0;
      lock_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state    <= SETTLE;
            cyc_cnt  <= '0;
            idx      <= 4'd9;
            lambda_q <= LAMBDA_MID;
            e_q      <= 1'b1;
            lock_q   <= 1'b0;
            busy_q   <= 1'b1;
          end
        end
        SETTLE, TRACK_SETTLE: begin
          if (cyc_cnt == SETTLE_LAST) begin
            state    <= (state == SETTLE) ? MEASURE : TRACK_MEASURE;
            cyc_cnt  <= '0;
            edge_cnt <= '0;
          end else begin
            cyc_cnt <= cyc_cnt + CYC_W'(1);
          end
        end
        MEASURE, TRACK_MEASURE: begin
          edge_cnt <= edge_cnt_nxt;
          if (cyc_cnt == WINDOW_LAST) begin
            state   <= (state == MEASURE) ? UPDATE : TRACK_UPDATE;
            cyc_cnt <= '0;
            meas_q  <= edge_cnt_nxt;
          end else begin
            cyc_cnt <= cyc_cnt + CYC_W'(1);
          end
        end
        UPDATE: begin
          lambda_q <= sar_lambda;
          lock_q   <= 1'b0;
          if (idx != 4'd0) begin
            idx   <= idx - 4'd1;
            state <= SETTLE;
          end else begin
            state <= TRACK_SETTLE;
          end
        end
        TRACK_UPDATE: begin
          if (err > TOL_S) begin
            if (lambda_q != 10'd0) lambda_q <= lambda_q - 10'd1;
            lock_q <= 1'b0;
          end else if (err < -TOL_S) begin
            if (lambda_q != 10'h3FF) lambda_q <= lambda_q + 10'd1;
            lock_q <= 1'b0;
          end else begin
            lock_q <= 1'b1;
          end
          state <= TRACK_SETTLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.lambda   = lambda_q;
  assign bus.e        = e_q;
  assign bus.lock     = lock_q;
  assign bus.busy     = busy_q;
  assign bus.meas_cnt = meas_q;

endmodule

// File: tb/tb_dco_freq_ctrl.sv
// Bench for dco_freq_ctrl: a rate-accurate DCO model closes the loop, a scoreboard
// holds the expected result of every lambda update and a monitor checks each one.
module tb_dco_freq_ctrl;
  localparam int CNT_W      = 12;
  localparam int WINDOW     = 256;
  localparam int SETTLE_CYC = 16;
  localparam int TOL        = 1;
  localparam int ITER       = SETTLE_CYC + WINDOW + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dco_freq_ctrl_if #(.CNT_W(CNT_W)) bus ();

  dco_freq_ctrl #(
    .CNT_W(CNT_W), .WINDOW(WINDOW), .SETTLE_CYC(SETTLE_CYC), .TOL(TOL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct { int cnt; int lam; bit lk; } exp_t;
  exp_t sb_q[$];

  int checks   = 0;
  int failures = 0;

  // environment: DCO edges per window = lambda/8 + dco_off
  int dco_off = 0;

  // reference model state
  int m_tgt  = 0;
  int m_lam  = 512;
  int m_res  = 0;
  int m_iter = 0;
  int m_cnt  = 0;
  bit m_lock = 1'b0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endfunction

  function automatic int fdco(int l);
    return l / 8 + dco_off;
  endfunction

  // largest lambda whose count does not exceed the target, 0 if none
  function automatic int sar_ref(int tgt);
    int best = 0;
    for (int l = 0; l < 1024; l++) if (fdco(l) <= tgt) best = l;
    return best;
  endfunction

  function automatic void model_reset();
    m_iter = 0; m_res = 0; m_lam = 512; m_lock = 1'b0; m_cnt = 0;
  endfunction

  function automatic void model_step();
    exp_t x;
    int   b;
    int   d;
    m_cnt = fdco(m_lam);
    if (m_iter < 10) begin
      b = 9 - m_iter;
      if (m_cnt <= m_tgt) m_res = m_lam;
      m_lam  = (b > 0) ? (m_res + (1 << (b - 1))) : m_res;
      m_lock = 1'b0;
    end else begin
      d = m_cnt - m_tgt;
      if (d > TOL) begin
        m_lam = (m_lam > 0) ? m_lam - 1 : 0;
        m_lock = 1'b0;
      end else if (d < -TOL) begin
        m_lam = (m_lam < 1023) ? m_lam + 1 : 1023;
        m_lock = 1'b0;
      end else begin
        m_lock = 1'b1;
      end
    end
    m_iter++;
    x.cnt = m_cnt; x.lam = m_lam; x.lk = m_lock;
    sb_q.push_back(x);
  endfunction

  task automatic set_target(int t);
    m_tgt = t;
    bus.target = CNT_W'(t);
  endtask

  task automatic do_start();
    model_reset();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) model_step();
    repeat (n * ITER) @(negedge clk);
  endtask

  task automatic do_stop(string tag);
    repeat ($urandom_range(20, 250)) @(negedge clk);
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    chk({tag, "_e"},      bus.e, 0);
    chk({tag, "_busy"},   bus.busy, 0);
    chk({tag, "_lock"},   bus.lock, 0);
    chk({tag, "_lambda"}, bus.lambda, m_lam);
    chk({tag, "_meas"},   bus.meas_cnt, m_cnt);
    chk({tag, "_drain"},  sb_q.size(), 0);
    sb_q.delete();
  endtask

  task automatic chk_reset(string tag);
    chk({tag, "_lambda"}, bus.lambda, 512);
    chk({tag, "_e"},      bus.e, 0);
    chk({tag, "_lock"},   bus.lock, 0);
    chk({tag, "_busy"},   bus.busy, 0);
    chk({tag, "_meas"},   bus.meas_cnt, 0);
  endtask

  // DCO model: phase accumulator gives exactly N one-cycle pulses in any WINDOW-cycle span
  initial begin
    int acc;
    acc = $urandom_range(0, WINDOW - 1);
    bus.fb_in = 1'b0;
    forever begin
      @(negedge clk);
      acc += int'(bus.lambda) / 8 + dco_off;
      if (acc >= WINDOW) begin
        acc -= WINDOW;
        bus.fb_in = 1'b1;
      end else begin
        bus.fb_in = 1'b0;
      end
    end
  end

  // monitor: arms on busy rising, checks one scoreboard entry per completed iteration
  initial begin
    bit   pb;
    bit   armed;
    int   cnt;
    exp_t x;
    pb = 1'b0; armed = 1'b0; cnt = 0;
    forever begin
      @(negedge clk);
      if (!bus.busy) begin
        armed = 1'b0;
      end else if (!pb) begin
        armed = 1'b1;
        cnt   = 0;
        chk("start_e",      bus.e, 1);
        chk("start_lambda", bus.lambda, 512);
        chk("start_lock",   bus.lock, 0);
      end else if (armed) begin
        cnt++;
        if (cnt == ITER) begin
          cnt = 0;
          if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_unexpected: actual=update required=none lambda=%0d", bus.lambda);
          end else begin
            x = sb_q.pop_front();
            chk("upd_meas",   bus.meas_cnt, x.cnt);
            chk("upd_lambda", bus.lambda, x.lam);
            chk("upd_lock",   bus.lock, x.lk);
          end
        end
      end
      pb = bus.busy;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "timeout");
  end

  initial begin
    int t;
    rst = 1'b1; bus.start = 1'b0; bus.stop = 1'b0; bus.target = '0;
    repeat (3) @(negedge clk);
    chk_reset("rst");
    rst = 1'b0;

    // SAR to 519, lock, then a +3 DCO shift pulls lambda down to 503
    set_target(64);
    do_start();
    run(10);
    chk("sar64_ref", bus.lambda, sar_ref(64));
    chk("sar64_const", bus.lambda, 519);
    run(1);
    chk("lock64", bus.lock, 1);
    dco_off = 3;
    run(20);
    chk("shift_lambda", bus.lambda, 503);
    chk("shift_lock", bus.lock, 1);
    do_stop("stop_track");
    dco_off = 0;

    bus.start = 1'b1; bus.stop = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.stop = 1'b0;
    chk("startstop_busy", bus.busy, 0);
    chk("startstop_e", bus.e, 0);
    repeat (5) @(negedge clk);
    chk("startstop_idle", bus.busy, 0);

    // unreachable target saturates high; zero target settles at 7
    set_target(200);
    do_start();
    run(10);
    chk("sar200", bus.lambda, 1023);
    run(2);
    chk("sat200_lock", bus.lock, 0);
    do_stop("stop_sat");

    set_target(0);
    do_start();
    run(11);
    chk("sar0_lambda", bus.lambda, 7);
    chk("sar0_lock", bus.lock, 1);
    do_stop("stop_zero");

    // stop early, inside the first measurement window
    set_target(64);
    do_start();
    repeat (100) @(negedge clk);
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    chk("stopmeas_e", bus.e, 0);
    chk("stopmeas_busy", bus.busy, 0);
    chk("stopmeas_lambda", bus.lambda, 512);
    sb_q.delete();

    // reset while tracking, then rerun
    do_start();
    run(11);
    repeat ($urandom_range(20, 250)) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_reset("rst_mid");
    chk("rst_drain", sb_q.size(), 0);
    rst = 1'b0;
    do_start();
    run(11);
    chk("rerun_lambda", bus.lambda, 519);
    chk("rerun_lock", bus.lock, 1);
    do_stop("stop_rerun");

    // random targets, with a mid-track target change
    for (int r = 0; r < 3; r++) begin
      set_target($urandom_range(0, 127));
      do_start();
      run(10);
      chk("rand_sar", bus.lambda, sar_ref(m_tgt));
      run(2);
      t = m_tgt + $urandom_range(0, 12) - 6;
      if (t < 0) t = 0;
      if (t > 127) t = 127;
      set_target(t);
      run(8);
      do_stop("stop_rand");
    end

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dco_freq_ctrl.md
Name: dco_freq_ctrl

Overview:
Digital frequency-acquisition controller directly upstream of the DCO; it drives the DCO's 10-bit control word `lambda` and enable `e`. It counts rising edges of a divided DCO feedback signal over a fixed window of reference-clock cycles and compares the count against a programmable target. A 10-step successive-approximation (SAR) search sets `lambda`, then a ±1 tracking loop holds lock. DCO frequency is monotonic non-decreasing in `lambda`.

Parameters:
CNT_W, 12, width of the edge counter, `target` and `meas_cnt`
WINDOW, 256, measurement window length in clk cycles (≥2)
SETTLE_CYC, 16, clk cycles of DCO settling after each `lambda` change (≥1)
TOL, 1, tracking dead-band in counts

Ports:
clk  in  1  reference clock; all logic is on its rising edge
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle request to begin acquisition; sampled only in IDLE
stop  in  1  synchronous abort; valid in any state
target  in  CNT_W  desired feedback edge count per window
fb_in  in  1  divided DCO feedback, asynchronous to clk; its frequency must be < clk/2
lambda  out  10  DCO control word, registered
e  out  1  DCO enable, registered
lock  out  1  frequency lock indicator
busy  out  1  high in any state other than IDLE
meas_cnt  out  CNT_W  last completed window count

Behaviour:
- Reset: `lambda` = 10'b1000000000, `e` = 0, `lock` = 0, `busy` = 0, `meas_cnt` = 0, `state` = IDLE, SAR bit index = 9, all counters and synchronizer flops = 0. Reset mid-operation behaves identically.
- Feedback path: `fb_in` passes through a 2-flop synchronizer plus a third flop. An edge is counted when sync2 = 1 and sync3 = 0.
- Edge counter: cleared on entry to MEASURE and saturates at all-ones.
- States: IDLE, SETTLE, MEASURE, UPDATE, TRACK_SETTLE, TRACK_MEASURE, TRACK_UPDATE.
- IDLE + `start` (and `stop` = 0): next cycle `e` = 1, `busy` = 1, `lambda` = 10'b1000000000, bit index = 9, go to SETTLE.
- SETTLE / TRACK_SETTLE: stay exactly SETTLE_CYC cycles, then go to the matching MEASURE state.
- MEASURE / TRACK_MEASURE: stay exactly WINDOW cycles counting edges. On the last cycle the final count (including an edge detected that cycle) is latched into `meas_cnt` at the transition to UPDATE.
- UPDATE (1 cycle, SAR step):
  - If `meas_cnt` > `target`, clear `lambda`[idx]; otherwise keep it.
  - If idx > 0: set `lambda`[idx-1], decrement idx, go to SETTLE.
  - If idx = 0: go to TRACK_SETTLE with `lock` = 0.
  - Result: SAR yields the largest `lambda` whose count is ≤ `target`, or 0 if none.
- TRACK_UPDATE (1 cycle):
  - Error err = `meas_cnt` − `target`, computed in CNT_W+1-bit signed arithmetic.
  - err > TOL: `lambda` −1, saturating at 0; `lock` = 0.
  - err < −TOL: `lambda` +1, saturating at 1023; `lock` = 0.
  - Otherwise: `lambda` unchanged; `lock` = 1.
  - Then go to TRACK_SETTLE.
- Iteration time is SETTLE_CYC + WINDOW + 1 cycles. Full SAR takes 10 iterations; the first `lock` assertion is possible at the end of the 11th iteration.
- `stop` = 1 in any state: next cycle `state` = IDLE, `e` = 0, `lock` = 0, `busy` = 0; `lambda` and `meas_cnt` hold. `stop` has priority over `start` when both are high in the same cycle.
- `target` is sampled at each UPDATE/TRACK_UPDATE. Changing it mid-track is legal and takes effect at the next update.
- `start` outside IDLE is ignored.

Test Plan:
1. Bench DCO model yields floor(`lambda`/8) `fb_in` edges per window; `rst` high for 3 cycles → `lambda` = 512, `e` = 0, `lock` = 0, `busy` = 0, `meas_cnt` = 0. `start` pulse → `e` = 1 and `busy` = 1 on the next cycle.
2. Same model, `target` = 64, default params → `lambda` = 519 after 10 SAR iterations (10×273 cycles). `lock` = 1 at the first TRACK_UPDATE (273 cycles later); `lambda` stays 519.
3. Locked at 519, then the model shifts to floor(`lambda`/8)+3 → `meas_cnt` = 67 > 65, so `lock` drops. `lambda` decrements by 1 per iteration until the count is ≤ 65 at `lambda` = 503; `lock` then reasserts.
4. `target` = 200 (unreachable) → SAR keeps all bits, `lambda` = 1023; tracking saturates at 1023 and `lock` stays 0. `target` = 0 → `lambda` = 7, `lock` = 1.
5. `stop` asserted mid-MEASURE → next cycle `e` = 0, `busy` = 0, `lock` = 0, `lambda` held. `start` and `stop` asserted together in IDLE → remains in IDLE.
6. `rst` asserted mid-TRACK → next cycle all outputs at reset values; a subsequent `start` reruns the SAR and reproduces `lambda` = 519 for `target` = 64.
